// File: rtl/bus_port_fifo.sv
// Bus endpoint: a TX FIFO feeding the bus arbiter and an RX FIFO filtered by destination ID.
// Both queues are first-word-fall-through, and their storage is cleared by reset.
module bus_port_fifo #(
   parameter int          pckg_sz   = 16,
   parameter int          depth     = 8,
   parameter logic [7:0]  id        = 8'd0,
   parameter logic [7:0]  broadcast = {8{1'b1}}
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   wr_en,
   input  logic [pckg_sz-1:0]     wr_data,
   output logic                   tx_full,
   output logic [$clog2(depth):0] tx_count,
   output logic                   pndng,
   output logic [pckg_sz-1:0]     D_pop,
   input  logic                   pop,
   input  logic                   push,
   input  logic [pckg_sz-1:0]     D_push,
   input  logic                   rd_en,
   output logic [pckg_sz-1:0]     rd_data,
   output logic                   rx_valid,
   output logic [$clog2(depth):0] rx_count,
   output logic [3:0]             err_flags
);

   localparam int ptr_w = $clog2(depth);
   localparam int cnt_w = ptr_w + 1;
   localparam logic [cnt_w-1:0] full_cnt = cnt_w'(depth);
   localparam logic [ptr_w-1:0] ptr_one  = ptr_w'(1);
   localparam logic [cnt_w-1:0] cnt_one  = cnt_w'(1);

   logic [pckg_sz-1:0] tx_mem_reg [depth];
   logic [pckg_sz-1:0] rx_mem_reg [depth];
   logic [ptr_w-1:0]   tx_rd_ptr_reg, tx_wr_ptr_reg, rx_rd_ptr_reg, rx_wr_ptr_reg;
   logic [cnt_w-1:0]   tx_count_reg, tx_count_next, rx_count_reg, rx_count_next;
   logic [3:0]         err_reg, err_next;

   logic tx_empty, tx_is_full, tx_do_pop, tx_do_wr;
   logic rx_empty, rx_is_full, rx_do_rd, rx_do_wr;
   logic dest_match, rx_accept;

   assign tx_empty   = (tx_count_reg == '0);
   assign tx_is_full = (tx_count_reg == full_cnt);
   assign rx_empty   = (rx_count_reg == '0);
   assign rx_is_full = (rx_count_reg == full_cnt);

   // A pop frees the head slot in the same cycle, so a full FIFO still takes a concurrent write.
   assign tx_do_pop = pop & ~tx_empty;
   assign tx_do_wr  = wr_en & (~tx_is_full | tx_do_pop);

   assign dest_match = (D_push[pckg_sz-1 -: 8] == id) || (D_push[pckg_sz-1 -: 8] == broadcast);
   assign rx_accept  = push & dest_match;
   assign rx_do_rd   = rd_en & ~rx_empty;
   assign rx_do_wr   = rx_accept & (~rx_is_full | rx_do_rd);

   always_comb begin
      tx_count_next = tx_count_reg;
      case ({tx_do_wr, tx_do_pop})
         2'b10:   tx_count_next = tx_count_reg + cnt_one;
         2'b01:   tx_count_next = tx_count_reg - cnt_one;
         default: tx_count_next = tx_count_reg;
      endcase
      rx_count_next = rx_count_reg;
      case ({rx_do_wr, rx_do_rd})
         2'b10:   rx_count_next = rx_count_reg + cnt_one;
         2'b01:   rx_count_next = rx_count_reg - cnt_one;
         default: rx_count_next = rx_count_reg;
      endcase
      err_next = err_reg | {push & ~dest_match,
                            rx_accept & rx_is_full & ~rd_en,
                            pop & tx_empty,
                            wr_en & tx_is_full & ~pop};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < depth; i++) begin
            tx_mem_reg[i] <= '0;
            rx_mem_reg[i] <= '0;
         end
         tx_rd_ptr_reg <= '0;
         tx_wr_ptr_reg <= '0;
         rx_rd_ptr_reg <= '0;
         rx_wr_ptr_reg <= '0;
         tx_count_reg  <= '0;
         rx_count_reg  <= '0;
         err_reg       <= '0;
      end else begin
         if (tx_do_wr) begin
            tx_mem_reg[tx_wr_ptr_reg] <= wr_data;
            tx_wr_ptr_reg <= tx_wr_ptr_reg + ptr_one;
         end
         if (tx_do_pop)
            tx_rd_ptr_reg <= tx_rd_ptr_reg + ptr_one;
         if (rx_do_wr) begin
            rx_mem_reg[rx_wr_ptr_reg] <= D_push;
            rx_wr_ptr_reg <= rx_wr_ptr_reg + ptr_one;
         end
         if (rx_do_rd)
            rx_rd_ptr_reg <= rx_rd_ptr_reg + ptr_one;
         tx_count_reg <= tx_count_next;
         rx_count_reg <= rx_count_next;
         err_reg      <= err_next;
      end
   end

   // Outputs depend only on registered state; the power-of-two depth makes pointer wrap free.
   assign tx_full   = tx_is_full;
   assign tx_count  = tx_count_reg;
   assign pndng     = ~tx_empty;
   assign D_pop     = tx_mem_reg[tx_rd_ptr_reg];
   assign rd_data   = rx_mem_reg[rx_rd_ptr_reg];
   assign rx_valid  = ~rx_empty;
   assign rx_count  = rx_count_reg;
   assign err_flags = err_reg;

endmodule

// File: tb/tb_bus_port_fifo.sv
// Directed checks of bus_port_fifo (id = 2, depth = 8, 16-bit packets).
module tb_bus_port_fifo;

   logic        clk = 1'b0;
   logic        reset;
   logic        wr_en, pop, push, rd_en;
   logic [15:0] wr_data, D_push;
   logic        tx_full, pndng, rx_valid;
   logic [3:0]  tx_count, rx_count, err_flags;
   logic [15:0] D_pop, rd_data;

   int checks_cnt = 0;
   int errors_cnt = 0;

   bus_port_fifo #(.pckg_sz(16), .depth(8), .id(8'd2), .broadcast(8'hFF)) dut (
      .clk(clk), .reset(reset),
      .wr_en(wr_en), .wr_data(wr_data),
      .tx_full(tx_full), .tx_count(tx_count),
      .pndng(pndng), .D_pop(D_pop), .pop(pop),
      .push(push), .D_push(D_push),
      .rd_en(rd_en), .rd_data(rd_data),
      .rx_valid(rx_valid), .rx_count(rx_count),
      .err_flags(err_flags)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks_cnt++;
      if (obs !== exp) begin
         errors_cnt++;
         $display("FAIL %s got %h expected %h", tag, obs, exp);
      end else begin
         $display("ok   %s = %h", tag, obs);
      end
   endtask

   // Advance one edge; outputs are sampled 1 time unit after it.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      wr_en = 0; pop = 0; push = 0; rd_en = 0;
   endtask

   initial begin
      idle();
      wr_data = '0; D_push = '0;
      reset = 1'b1;
      #2;
      check("async_rst_tx_count", 32'(tx_count), 32'd0);
      check("async_rst_err", 32'(err_flags), 32'd0);
      tick(); tick();
      reset = 1'b0;
      check("rst_D_pop", 32'(D_pop), 32'h0);
      check("rst_rd_data", 32'(rd_data), 32'h0);
      check("rst_pndng", 32'(pndng), 32'd0);
      check("rst_tx_full", 32'(tx_full), 32'd0);

      // single write then pop
      wr_en = 1; wr_data = 16'h0155;
      tick(); idle();
      check("w1_pndng", 32'(pndng), 32'd1);
      check("w1_D_pop", 32'(D_pop), 32'h0155);
      check("w1_tx_count", 32'(tx_count), 32'd1);
      pop = 1;
      tick(); idle();
      check("p1_pndng", 32'(pndng), 32'd0);
      check("p1_tx_count", 32'(tx_count), 32'd0);

      // fill TX, overflow, simultaneous pop+write while full
      for (int i = 0; i < 8; i++) begin
         wr_en = 1; wr_data = 16'h1000 + 16'(i);
         tick();
      end
      idle();
      check("fill_tx_full", 32'(tx_full), 32'd1);
      check("fill_tx_count", 32'(tx_count), 32'd8);
      wr_en = 1; wr_data = 16'hBEEF;
      tick(); idle();
      check("ovf_err", 32'(err_flags), 32'b0001);
      check("ovf_tx_count", 32'(tx_count), 32'd8);
      check("ovf_D_pop", 32'(D_pop), 32'h1000);
      wr_en = 1; pop = 1; wr_data = 16'h2008;
      tick(); idle();
      check("wp_tx_count", 32'(tx_count), 32'd8);
      check("wp_tx_full", 32'(tx_full), 32'd1);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("drain_tx_%0d", i), 32'(D_pop),
               (i < 7) ? 32'h1001 + 32'(i) : 32'h2008);
         pop = 1;
         tick(); idle();
      end
      check("drain_tx_count", 32'(tx_count), 32'd0);

      // pop while empty
      pop = 1;
      tick(); idle();
      check("unf_err", 32'(err_flags), 32'b0011);
      check("unf_tx_count", 32'(tx_count), 32'd0);
      check("unf_rx_count", 32'(rx_count), 32'd0);

      // RX destination filter
      push = 1; D_push = 16'h02AB;
      tick(); idle();
      check("rx1_valid", 32'(rx_valid), 32'd1);
      check("rx1_data", 32'(rd_data), 32'h02AB);
      push = 1; D_push = 16'hFF12;
      tick(); idle();
      check("bcast_rx_count", 32'(rx_count), 32'd2);
      push = 1; D_push = 16'h0312;
      tick(); idle();
      check("misroute_rx_count", 32'(rx_count), 32'd2);
      check("misroute_err", 32'(err_flags), 32'b1011);
      rd_en = 1;
      tick(); idle();
      check("rd1_data", 32'(rd_data), 32'hFF12);
      rd_en = 1;
      tick(); idle();
      check("rd2_valid", 32'(rx_valid), 32'd0);
      rd_en = 1;
      tick(); idle();
      check("rd_empty_err", 32'(err_flags), 32'b1011);
      check("rd_empty_count", 32'(rx_count), 32'd0);

      // RX full, overflow, then push with rd_en
      for (int i = 0; i < 8; i++) begin
         push = 1; D_push = 16'h0210 + 16'(i);
         tick();
      end
      idle();
      check("fill_rx_count", 32'(rx_count), 32'd8);
      push = 1; D_push = 16'h0200;
      tick(); idle();
      check("rx_ovf_err", 32'(err_flags), 32'b1111);
      check("rx_ovf_count", 32'(rx_count), 32'd8);
      check("rx_ovf_head", 32'(rd_data), 32'h0210);
      push = 1; rd_en = 1; D_push = 16'h0200;
      tick(); idle();
      check("rx_pr_count", 32'(rx_count), 32'd8);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("drain_rx_%0d", i), 32'(rd_data),
               (i < 7) ? 32'h0211 + 32'(i) : 32'h0200);
         rd_en = 1;
         tick(); idle();
      end
      check("drain_rx_valid", 32'(rx_valid), 32'd0);

      // reset mid-transfer: TX holds 5, RX holds 3
      for (int i = 0; i < 5; i++) begin
         wr_en = 1; wr_data = 16'h3000 + 16'(i);
         push = (i < 3); D_push = 16'h0230 + 16'(i);
         tick();
      end
      idle();
      check("pre_tx_count", 32'(tx_count), 32'd5);
      check("pre_rx_count", 32'(rx_count), 32'd3);
      #1 reset = 1'b1;
      #1;
      check("mid_rst_tx_count", 32'(tx_count), 32'd0);
      check("mid_rst_rx_count", 32'(rx_count), 32'd0);
      check("mid_rst_pndng", 32'(pndng), 32'd0);
      check("mid_rst_rx_valid", 32'(rx_valid), 32'd0);
      check("mid_rst_err", 32'(err_flags), 32'd0);
      check("mid_rst_D_pop", 32'(D_pop), 32'h0);
      tick();
      reset = 1'b0;
      wr_en = 1; wr_data = 16'h4444;
      push = 1; D_push = 16'h0255;
      tick(); idle();
      check("post_rst_tx_count", 32'(tx_count), 32'd1);
      check("post_rst_D_pop", 32'(D_pop), 32'h4444);
      check("post_rst_rx_count", 32'(rx_count), 32'd1);
      check("post_rst_rd_data", 32'(rd_data), 32'h0255);

      $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
      $finish;
   end

endmodule

// File: doc/bus_port_fifo.md
BUS_PORT_FIFO -- requirements
Module: bus_port_fifo

Interface
REQ-001 Parameter: pckg_sz, 16, packet width in bits; bits [pckg_sz-1:pckg_sz-8] are the destination ID.
REQ-002 Parameter: depth, 8, entries per FIFO; power of two, at least 2.
REQ-003 Parameter: id, 0, 8-bit port ID this endpoint answers to.
REQ-004 Parameter: broadcast, {8{1'b1}}, destination ID accepted by every port.
REQ-005 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-006 Port: reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-007 Port: wr_en  in  1  test-side write strobe into the TX FIFO.
REQ-008 Port: wr_data  in  pckg_sz  packet to enqueue for the bus.
REQ-009 Port: tx_full  out  1  TX FIFO holds depth entries.
REQ-010 Port: tx_count  out  $clog2(depth)+1  TX occupancy.
REQ-011 Port: pndng  out  1  TX FIFO non-empty (request to bus arbiter).
REQ-012 Port: D_pop  out  pckg_sz  TX FIFO head, first-word-fall-through.
REQ-013 Port: pop  in  1  bus dequeues the TX head.
REQ-014 Port: push  in  1  bus delivers D_push to this port.
REQ-015 Port: D_push  in  pckg_sz  packet from bus.
REQ-016 Port: rd_en  in  1  test-side dequeue from the RX FIFO.
REQ-017 Port: rd_data  out  pckg_sz  RX FIFO head, first-word-fall-through.
REQ-018 Port: rx_valid  out  1  RX FIFO non-empty.
REQ-019 Port: rx_count  out  $clog2(depth)+1  RX occupancy.
REQ-020 Port: err_flags  out  4  sticky {misroute, rx_overflow, tx_underflow, tx_overflow}.

Function
REQ-021 TX and RX are independent circular buffers, each with a read pointer, a write pointer and a count; pointers wrap from depth-1 to 0.
REQ-022 pndng, D_pop, tx_full, rx_valid, rd_data and the counts are driven from registered state only, with no combinational path from any input.
REQ-023 wr_en with TX not full enqueues wr_data; pndng rises on the edge after a write into an empty FIFO (latency 1).
REQ-024 pop with TX non-empty advances the read pointer; D_pop shows the next entry in the following cycle.
REQ-025 wr_en and pop in the same cycle: both take effect and tx_count is unchanged; this also holds when TX is full.
REQ-026 wr_en while full, without a simultaneous pop: data is dropped, state is unchanged, and tx_overflow is set.
REQ-027 pop while TX is empty: ignored, and tx_underflow is set.
REQ-028 push is accepted only when the destination field equals id or broadcast; any other destination is dropped and sets misroute.
REQ-029 An accepted push with RX not full enqueues D_push; rx_valid rises on the next edge.
REQ-030 An accepted push while RX is full with no simultaneous rd_en: dropped, and rx_overflow is set; with rd_en in the same cycle, both take effect.
REQ-031 rd_en while RX is empty: ignored, with no flag.
REQ-032 err_flags bits are sticky and are cleared only by reset.
REQ-033 Counts are never negative and never exceed depth; tx_full is asserted exactly when tx_count equals depth.

Reset
REQ-034 Asserting reset immediately zeroes pointers, counts, pndng, rx_valid and err_flags; tx_full = 0.
REQ-035 After reset, D_pop and rd_data read 0 (storage cleared) until the first write.
REQ-036 Reset asserted mid-transfer discards all queued packets; nothing in flight survives.
REQ-037 On the first rising edge after reset deasserts, wr_en and push are accepted normally.

Verification
REQ-038 Reset, then write 16'h0155 -> next cycle pndng=1, D_pop=16'h0155, tx_count=1; pop -> pndng=0, tx_count=0.
REQ-039 Write 8 packets (depth 8), then a ninth -> tx_full=1, ninth dropped, err_flags[0]=1; pop with write in the same cycle -> tx_count stays 8, order preserved.
REQ-040 pop when empty -> err_flags[1]=1, counts unchanged; no other flag set.
REQ-041 With id=2: push 16'h02AB -> rx_valid=1, rd_data=16'h02AB; push 16'hFF12 accepted; push 16'h0312 -> dropped, err_flags[3]=1.
REQ-042 Fill RX, push 16'h0200 -> err_flags[2]=1; repeat with rd_en in the same cycle -> accepted, rx_count stays 8.
REQ-043 Assert reset while TX holds 5 and RX holds 3 -> all counts 0, pndng=0, rx_valid=0, err_flags=0 without waiting for a clock edge.
